// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, FSM states and trellis helpers for viterbi_decoder_p
package viterbi_pkg;
    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} state_t;

    // Encoder output {c0,c1} when input u is applied in trellis state s={u[t-1],u[t-2]}
    function automatic logic [1:0] branch_out(input logic [1:0] s, input logic u);
        logic [K-1:0] taps;
        taps = {u, s};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction
endpackage

// File: rtl/vit_acs.sv
// rtl/vit_acs.sv - saturating add-compare-select for one destination trellis state
module vit_acs #(
    parameter int MW = 4
) (
    input  logic [MW-1:0] metric0,
    input  logic [MW-1:0] metric1,
    input  logic [1:0]    branch0,
    input  logic [1:0]    branch1,
    output logic [MW-1:0] metric,
    output logic          decision
);
    logic [MW:0]   sum0;
    logic [MW:0]   sum1;
    logic [MW-1:0] sat0;
    logic [MW-1:0] sat1;

    assign sum0 = {1'b0, metric0} + {{(MW-1){1'b0}}, branch0};
    assign sum1 = {1'b0, metric1} + {{(MW-1){1'b0}}, branch1};
    assign sat0 = sum0[MW] ? '1 : sum0[MW-1:0];
    assign sat1 = sum1[MW] ? '1 : sum1[MW-1:0];

    // Ties resolve to predecessor b=0
    assign decision = (sat1 < sat0);
    assign metric   = decision ? sat1 : sat0;
endmodule

// File: rtl/viterbi_decoder_p.sv
// rtl/viterbi_decoder_p.sv - variable-length hard-decision Viterbi decoder, rate 1/2 K=3
module viterbi_decoder_p
    import viterbi_pkg::*;
#(
    parameter int MAX_DBITS = 7,
    parameter int LEN_W     = $clog2(MAX_DBITS + 1),
    parameter int ERR_W     = $clog2(2 * MAX_DBITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       nbits,
    input  logic                   tail,
    input  logic [2*MAX_DBITS-1:0] rstring,
    output logic                   busy,
    output logic [MAX_DBITS-1:0]   dstring,
    output logic [ERR_W-1:0]       err_cnt,
    output logic                   done
);
    localparam int SW = 2 * MAX_DBITS;

    state_t               fsm, fsm_next;
    logic [LEN_W-1:0]     nb, step, nbits_clamped;
    logic                 tail_mode, primed;
    logic [SW-1:0]        rsh, rsh_init;
    logic [1:0]           rpair;
    logic [ERR_W-1:0]     metric [4];
    logic [ERR_W-1:0]     acs_metric [4];
    logic [3:0]           acs_dec;
    logic [3:0]           decision [MAX_DBITS];
    logic [1:0]           tb_state, best, start_sel;
    logic [MAX_DBITS-1:0] sreg, sreg_next;

    assign nbits_clamped = (int'(nbits) > MAX_DBITS) ? LEN_W'(MAX_DBITS) : nbits;
    // Left-justify the frame so each ACS step consumes the top pair
    assign rsh_init = rstring << (2 * (MAX_DBITS - int'(nbits_clamped)));
    assign rpair    = rsh[SW-1 -: 2];

    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        logic [1:0] bm0, bm1;
        assign bm0 = hamming2(branch_out({NS[0], 1'b0}, NS[1]), rpair);
        assign bm1 = hamming2(branch_out({NS[0], 1'b1}, NS[1]), rpair);
        vit_acs #(.MW(ERR_W)) u_acs (
            .metric0  (metric[{NS[0], 1'b0}]),
            .metric1  (metric[{NS[0], 1'b1}]),
            .branch0  (bm0),
            .branch1  (bm1),
            .metric   (acs_metric[g]),
            .decision (acs_dec[g])
        );
    end

    always_comb begin
        best = 2'd0;
        for (int i = 1; i < 4; i++)
            if (metric[i] < metric[best]) best = 2'(i);
        start_sel = tail_mode ? 2'd0 : best;
    end

    // Traceback visits the last step first; bit for step t lands at [nb-1-t]
    always_comb begin
        sreg_next = sreg;
        if (fsm == TRACE && primed && step != '0)
            sreg_next[nb - step] = tb_state[1];
    end

    always_comb begin
        fsm_next = fsm;
        busy     = 1'b0;
        done     = 1'b0;
        case (fsm)
            IDLE: if (start) fsm_next = (nbits_clamped == '0) ? TRACE : ACS;
            ACS: begin
                busy = 1'b1;
                if (step == nb - 1'b1) fsm_next = TRACE;
            end
            TRACE: begin
                busy = 1'b1;
                if (primed ? (step <= LEN_W'(1)) : (nb == '0)) fsm_next = DONE;
            end
            DONE: begin
                done     = 1'b1;
                fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            nb        <= '0;
            step      <= '0;
            tail_mode <= 1'b0;
            primed    <= 1'b0;
            rsh       <= '0;
            tb_state  <= '0;
            sreg      <= '0;
            dstring   <= '0;
            err_cnt   <= '0;
            for (int i = 0; i < 4; i++) metric[i] <= '0;
            for (int i = 0; i < MAX_DBITS; i++) decision[i] <= '0;
        end else begin
            fsm  <= fsm_next;
            sreg <= sreg_next;
            case (fsm)
                IDLE: if (start) begin
                    nb        <= nbits_clamped;
                    tail_mode <= tail;
                    rsh       <= rsh_init;
                    step      <= '0;
                    primed    <= 1'b0;
                    sreg      <= '0;
                    metric[0] <= '0;
                    for (int i = 1; i < 4; i++) metric[i] <= '1;
                end
                ACS: begin
                    for (int i = 0; i < 4; i++) metric[i] <= acs_metric[i];
                    decision[step] <= acs_dec;
                    rsh  <= rsh << 2;
                    step <= step + 1'b1;
                end
                TRACE: begin
                    // First TRACE cycle only picks the start state from the final metrics
                    if (!primed) begin
                        primed   <= 1'b1;
                        step     <= nb;
                        tb_state <= start_sel;
                    end else if (step != '0) begin
                        tb_state <= {tb_state[0], decision[step - 1'b1][tb_state]};
                        step     <= step - 1'b1;
                    end
                end
                default: ;
            endcase
            if (fsm_next == DONE) begin
                dstring <= sreg_next;
                err_cnt <= metric[start_sel];
            end
        end
    end
endmodule

// File: tb/tb_viterbi_decoder_p.sv
// tb/tb_viterbi_decoder_p.sv - directed and encoder-model self-checking bench for viterbi_decoder_p
module tb_viterbi_decoder_p;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        tail = 1'b0;
    logic [2:0]  nbits = '0;
    logic [13:0] rstring = '0;
    logic        busy;
    logic        done;
    logic [6:0]  dstring;
    logic [3:0]  err_cnt;

    int compared = 0;
    int mismatched = 0;

    viterbi_decoder_p dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .nbits   (nbits),
        .tail    (tail),
        .rstring (rstring),
        .busy    (busy),
        .dstring (dstring),
        .err_cnt (err_cnt),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] encode(input logic [6:0] src, input int n);
        logic [1:0]  s;
        logic        u;
        logic [13:0] r;
        s = 2'b00;
        r = '0;
        for (int t = 0; t < n; t++) begin
            u = src[n-1-t];
            r[2*n-1-2*t] = u ^ s[1] ^ s[0];
            r[2*n-2-2*t] = u ^ s[0];
            s = {u, s[1]};
        end
        return r;
    endfunction

    // lat = negedges after the accepting edge until done is seen (0 = right after that edge)
    task automatic run_frame(input logic [2:0] n, input logic t, input logic [13:0] r,
                             input int glitch, output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1; nbits = n; tail = t; rstring = r;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
            if (lat == glitch) begin
                start = 1'b1; nbits = 3'd2; tail = ~t; rstring = ~r;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int          lat, bc, n, nerr, idx;
        logic        t;
        logic [6:0]  src;
        logic [13:0] r;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dstring", dstring, 0);
        check("reset_err", err_cnt, 0);
        rst = 1'b1;

        run_frame(3'd6, 1'b1, 14'b111000010111, -1, lat, bc);
        check("clean_lat", lat, 13);
        check("clean_dstring", dstring, 7'b0101100);
        check("clean_err", err_cnt, 0);

        run_frame(3'd6, 1'b1, 14'b011000010111, -1, lat, bc);
        check("flip_dstring", dstring, 7'b0101100);
        check("flip_err", err_cnt, 1);

        run_frame(3'd3, 1'b0, 14'b00000000111000, -1, lat, bc);
        check("n3_lat", lat, 7);
        check("n3_busy_cycles", bc, 7);
        check("n3_dstring", dstring, 7'b0000101);
        check("n3_err", err_cnt, 0);

        run_frame(3'd0, 1'b0, 14'h3fff, -1, lat, bc);
        check("n0_lat", lat, 1);
        check("n0_dstring", dstring, 0);
        check("n0_err", err_cnt, 0);

        src = 7'b1101001;
        run_frame(3'd7, 1'b0, encode(src, 7), -1, lat, bc);
        check("n7_lat", lat, 15);
        check("n7_dstring", dstring, 7'b1101001);
        check("n7_err", err_cnt, 0);

        run_frame(3'd6, 1'b1, 14'b111000010111, 3, lat, bc);
        check("glitch_lat", lat, 13);
        check("glitch_dstring", dstring, 7'b0101100);
        check("glitch_err", err_cnt, 0);

        @(negedge clk);
        start = 1'b1; nbits = 3'd6; tail = 1'b1; rstring = 14'b011000010111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dstring", dstring, 0);
        check("midrst_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        bc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) bc++;
        end
        check("midrst_no_done", bc, 0);

        run_frame(3'd3, 1'b0, 14'b00000000111000, -1, lat, bc);
        check("post_rst_dstring", dstring, 7'b0000101);
        check("post_rst_err", err_cnt, 0);

        for (int f = 0; f < 200; f++) begin
            n = $urandom_range(0, 7);
            t = 1'($urandom_range(0, 1));
            src = 7'($urandom) & 7'((1 << n) - 1);
            if (t) src &= ~7'b0000011;
            r = encode(src, n);
            nerr = 0;
            if (t && n >= 4 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 2 * n - 1);
                r[idx] = ~r[idx];
                nerr = 1;
            end
            run_frame(3'(n), t, r, -1, lat, bc);
            check("rand_lat", lat, 2 * n + 1);
            check("rand_dstring", dstring, src);
            check("rand_err", err_cnt, nerr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
